rr_arbiter_4: RTL and testbench

- Four-requester round-robin arbiter with registered, held grants. Shares one downstream resource among four request lines.
- Output encoding matches the team's 4-to-2 encoder: one-hot grant, 2-bit index, valid flag. The rotating pointer replaces fixed priority.
- Sits between request sources and a shared datapath, e.g. a bus or memory port.

---
 rtl/rr_arbiter_4.sv | 63 ++++++
 tb/tb_rr_arbiter_4.sv | 113 +++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with registered, held grants.
// Define ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD cycles while others wait.
module rr_arbiter_4 #(
  parameter int MAX_HOLD  = 8,
  parameter int RESET_PTR = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic [7:0] hold_cnt
);
  typedef enum logic {IDLE, GRANT} state_t;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  state_t     r_state, w_state_nx;
  logic [1:0] r_ptr, w_ptr_nx, r_idx, w_idx_nx, w_base, w_pick;
  logic [3:0] r_gnt, w_gnt_nx;
  logic [7:0] r_hold, w_hold_nx;
  logic       w_to, w_rel, w_scan, w_found;
  assign w_to = TO_EN && r_state == GRANT && r_hold == 8'(MAX_HOLD - 1) && |(req & ~r_gnt);
  always_comb begin
    w_rel = r_state == GRANT && (!req[r_idx] || w_to);
    w_scan = r_state == IDLE || w_rel;
    w_base = r_state == GRANT ? r_idx + 2'd1 : r_ptr;
    w_found = 1'b0;
    w_pick = w_base;
    // scanning downward lets the lowest rotation offset win
    for (int k = 3; k >= 0; k--)
      if (req[w_base + 2'(k)]) begin
        w_found = 1'b1;
        w_pick = w_base + 2'(k);
      end
    w_ptr_nx = w_rel ? r_idx + 2'd1 : r_ptr;
    w_state_nx = !w_scan ? r_state : w_found ? GRANT : IDLE;
    w_idx_nx = !w_scan ? r_idx : w_found ? w_pick : 2'd0;
    w_gnt_nx = !w_scan ? r_gnt : w_found ? 4'b0001 << w_pick : 4'b0000;
    w_hold_nx = w_scan ? 8'd0 : r_hold + {7'd0, r_hold != 8'hff};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr <= 2'(RESET_PTR);
      r_idx <= 2'd0;
      r_gnt <= 4'b0000;
      r_hold <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_ptr <= w_ptr_nx;
      r_idx <= w_idx_nx;
      r_gnt <= w_gnt_nx;
      r_hold <= w_hold_nx;
    end
  assign gnt = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_valid = |r_gnt;
  assign hold_cnt = r_hold;
endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: random requests against a behavioural round-robin model, plus literal checks.
module tb_rr_arbiter_4;
  localparam int MH = 4;
  localparam int RP = 0;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req = 4'b1111;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic gnt_valid;
  logic [7:0] hold_cnt;
  int n_tests = 0, n_fail = 0;
  int m_own = -1, m_ptr = RP, m_hold = 0;

  rr_arbiter_4 #(.MAX_HOLD(MH), .RESET_PTR(RP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .hold_cnt(hold_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int scan(input int b, input logic [3:0] r);
    for (int k = 0; k < 4; k++) if (r[(b + k) % 4]) return (b + k) % 4;
    return -1;
  endfunction

  // model: owner as an integer, -1 meaning idle
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_own = -1;
      m_ptr = RP;
      m_hold = 0;
    end else if (m_own < 0) begin
      m_own = scan(m_ptr, req);
      m_hold = 0;
    end else if (!req[m_own] || (TO && m_hold == MH - 1 && (req & ~(4'b0001 << m_own)) != 0)) begin
      m_ptr = (m_own + 1) % 4;
      m_own = scan(m_ptr, req);
      m_hold = 0;
    end else if (m_hold < 255) m_hold++;

  always @(negedge clk) begin
    chk("model_gnt", {28'd0, gnt}, m_own < 0 ? 0 : 32'd1 << m_own);
    chk("model_idx", {30'd0, gnt_idx}, m_own < 0 ? 0 : m_own);
    chk("model_valid", {31'd0, gnt_valid}, m_own >= 0);
    chk("model_hold", {24'd0, hold_cnt}, m_hold);
  end

  initial begin
    #1;
    chk("rst_gnt", {28'd0, gnt}, 4'b0000);
    chk("rst_valid", {31'd0, gnt_valid}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_gnt", {28'd0, gnt}, 4'b0001);
    chk("first_idx", {30'd0, gnt_idx}, 0);
    req = 4'b0000;
    @(negedge clk);
    chk("release_idle", {28'd0, gnt}, 4'b0000);
    req = 4'b0100;
    @(negedge clk);
    chk("single_gnt", {28'd0, gnt}, 4'b0100);
    chk("single_idx", {30'd0, gnt_idx}, 2);
    chk("single_valid", {31'd0, gnt_valid}, 1);
    req = 4'b0000;
    @(negedge clk);
    chk("single_drop", {28'd0, gnt}, 4'b0000);
    req = 4'b1000;
    @(negedge clk);
    chk("own3_gnt", {28'd0, gnt}, 4'b1000);
    req = 4'b0001;
    @(negedge clk);
    chk("wrap_gnt", {28'd0, gnt}, 4'b0001);
    req = 4'b0010;
    @(negedge clk);
    chk("move_gnt", {28'd0, gnt}, 4'b0010);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {28'd0, gnt}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1000;
    @(negedge clk);
    chk("post_rst", {28'd0, gnt}, 4'b1000);
    req = 4'b0001;
    @(negedge clk);
    repeat (9) @(negedge clk);
    chk("hold_count", {24'd0, hold_cnt}, 9);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(3) == 0) req[b] = ~req[b];
      if ($urandom_range(199) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else @(negedge clk);
    end
    req = 4'b1111;
    repeat (300) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
